// File: rtl/bch_dec_ctrl.sv
// Frame-level sequencer for the BCH decoder: steps through syndrome accumulation, the BM solver
// and the Chien search, and drives the datapath strobes and the done/error pulses.
module bch_dec_ctrl #(
    parameter int N      = 15,
    parameter int CNT_W  = 4,
    parameter int BM_TMO = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             abort,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic             syn_clr,
    output logic             syn_en,
    output logic             bm_start,
    input  logic             bm_done,
    output logic             chien_en,
    output logic [CNT_W-1:0] chien_idx,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             done,
    output logic             frame_err,
    output logic             tmo_err
);

    localparam int WAIT_W = $clog2(BM_TMO + 1);
    localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(N - 1);
    localparam logic [WAIT_W-1:0] TMO_LAST = WAIT_W'(BM_TMO - 1);

    typedef enum logic [1:0] {IDLE, SYN, BM, CHIEN} state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0]  chien_idx_q, chien_idx_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              bm_start_q, bm_start_d;
    logic              done_q, done_d;
    logic              frame_err_q, frame_err_d;
    logic              tmo_err_q, tmo_err_d;
    logic              bit_acc;

    assign bit_acc = (state_q == SYN) && in_valid;

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        chien_idx_d = chien_idx_q;
        wait_cnt_d  = wait_cnt_q;
        bm_start_d  = 1'b0;
        done_d      = 1'b0;
        frame_err_d = 1'b0;
        tmo_err_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d   = SYN;
                    bit_cnt_d = '0;
                end
            end
            SYN: begin
                // A frame is good only if in_last lands exactly on the N-th accepted bit.
                if (bit_acc) begin
                    if (in_last != (bit_cnt_q == LAST_IDX)) begin
                        state_d     = IDLE;
                        frame_err_d = 1'b1;
                    end else if (in_last) begin
                        state_d    = BM;
                        bm_start_d = 1'b1;
                        wait_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end
            end
            BM: begin
                if (bm_done) begin
                    state_d     = CHIEN;
                    chien_idx_d = '0;
                end else if (wait_cnt_q == TMO_LAST) begin
                    state_d   = IDLE;
                    tmo_err_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end
            CHIEN: begin
                if (out_ready) begin
                    if (chien_idx_q == LAST_IDX) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        chien_idx_d = chien_idx_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (abort) begin
            state_d     = IDLE;
            bm_start_d  = 1'b0;
            done_d      = 1'b0;
            frame_err_d = 1'b0;
            tmo_err_d   = 1'b0;
        end

        // Counters always rest at zero in IDLE, whichever way IDLE was reached.
        if (state_d == IDLE) begin
            bit_cnt_d   = '0;
            chien_idx_d = '0;
            wait_cnt_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            chien_idx_q <= '0;
            wait_cnt_q  <= '0;
            bm_start_q  <= 1'b0;
            done_q      <= 1'b0;
            frame_err_q <= 1'b0;
            tmo_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            chien_idx_q <= chien_idx_d;
            wait_cnt_q  <= wait_cnt_d;
            bm_start_q  <= bm_start_d;
            done_q      <= done_d;
            frame_err_q <= frame_err_d;
            tmo_err_q   <= tmo_err_d;
        end
    end

    assign in_ready  = (state_q == SYN);
    assign syn_clr   = (state_q == IDLE);
    assign syn_en    = bit_acc;
    assign chien_en  = (state_q == CHIEN) && out_ready;
    assign out_valid = (state_q == CHIEN);
    assign busy      = (state_q != IDLE);
    assign chien_idx = chien_idx_q;
    assign bm_start  = bm_start_q;
    assign done      = done_q;
    assign frame_err = frame_err_q;
    assign tmo_err   = tmo_err_q;

endmodule

// File: tb/tb_bch_dec_ctrl.sv
// Self-checking bench for bch_dec_ctrl: directed scenarios plus randomized frames checked
// against a frame-level expectation built from the bench's own stimulus.
module tb_bch_dec_ctrl;

    localparam int N      = 15;
    localparam int CNT_W  = 4;
    localparam int BM_TMO = 64;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             abort = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_last = 1'b0;
    logic             bm_done = 1'b0;
    logic             out_ready = 1'b0;
    logic             in_ready, syn_clr, syn_en, bm_start, chien_en;
    logic             out_valid, busy, done, frame_err, tmo_err;
    logic [CNT_W-1:0] chien_idx;

    int n_cmp = 0;
    int n_err = 0;

    bch_dec_ctrl #(.N(N), .CNT_W(CNT_W), .BM_TMO(BM_TMO)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .abort     (abort),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .syn_clr   (syn_clr),
        .syn_en    (syn_en),
        .bm_start  (bm_start),
        .bm_done   (bm_done),
        .chien_en  (chien_en),
        .chien_idx (chien_idx),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done),
        .frame_err (frame_err),
        .tmo_err   (tmo_err)
    );

    always #5 clk = ~clk;

    // {busy,in_ready,syn_en,syn_clr,bm_start,chien_en,out_valid,done,frame_err,tmo_err}
    function automatic logic [9:0] outs();
        return {busy, in_ready, syn_en, syn_clr, bm_start, chien_en, out_valid, done, frame_err, tmo_err};
    endfunction

    // Drives the IDLE bubble cycle and then nbits valid bits, in_last on bit last_at (1-based).
    task automatic feed_bits(input int nbits, input int last_at);
        @(negedge clk);
        in_valid = 1'b1;
        in_last  = 1'b0;
        for (int k = 0; k < nbits; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_last  = (k + 1 == last_at);
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        #1;
        n_cmp++;
        if (outs() !== 10'b0001000000 || chien_idx !== '0) begin
            n_err++;
            $display("FAIL reset_hold: outs=%b idx=%0d, want outs=0001000000 idx=0", outs(), chien_idx);
        end
        @(negedge clk);
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1;
        n_cmp++;
        if (outs() !== 10'b0001000000 || chien_idx !== '0) begin
            n_err++;
            $display("FAIL reset_release: outs=%b idx=%0d, want outs=0001000000 idx=0", outs(), chien_idx);
        end
    endtask

    task automatic test_normal_frame();
        int syn_cnt = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_last  = 1'b0;
        #1;
        n_cmp++;
        if (outs() !== 10'b0001000000) begin
            n_err++;
            $display("FAIL bubble: outs=%b, want 0001000000", outs());
        end
        for (int k = 0; k < N; k++) begin
            @(negedge clk);
            in_last = (k == N - 1);
            #1;
            if (syn_en) syn_cnt++;
            n_cmp++;
            if ({busy, in_ready, syn_en, syn_clr, bm_start} !== 5'b11100) begin
                n_err++;
                $display("FAIL syn_bit%0d: got %b, want 11100", k, {busy, in_ready, syn_en, syn_clr, bm_start});
            end
        end
        n_cmp++;
        if (syn_cnt != N) begin
            n_err++;
            $display("FAIL syn_en_count: got %0d, want %0d", syn_cnt, N);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        #1;
        n_cmp++;
        if ({busy, in_ready, bm_start, out_valid} !== 4'b1010) begin
            n_err++;
            $display("FAIL bm_start_cycle: got %b, want 1010", {busy, in_ready, bm_start, out_valid});
        end
        for (int d = 1; d <= 3; d++) begin
            @(negedge clk);
            bm_done = (d == 3);
            #1;
            n_cmp++;
            if ({bm_start, out_valid, tmo_err, busy} !== 4'b0001) begin
                n_err++;
                $display("FAIL bm_wait%0d: got %b, want 0001", d, {bm_start, out_valid, tmo_err, busy});
            end
        end
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            bm_done   = 1'b0;
            out_ready = 1'b1;
            #1;
            n_cmp++;
            if ({out_valid, chien_en, done} !== 3'b110 || chien_idx !== CNT_W'(i)) begin
                n_err++;
                $display("FAIL chien_out%0d: flags=%b idx=%0d, want flags=110 idx=%0d",
                         i, {out_valid, chien_en, done}, chien_idx, i);
            end
        end
        @(negedge clk);
        out_ready = 1'b0;
        #1;
        n_cmp++;
        if ({done, busy, out_valid} !== 3'b100) begin
            n_err++;
            $display("FAIL done_pulse: got %b, want 100", {done, busy, out_valid});
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if (done !== 1'b0) begin
            n_err++;
            $display("FAIL done_width: got %b, want 0", done);
        end
    endtask

    task automatic test_frame_err();
        feed_bits(10, 10);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        #1;
        n_cmp++;
        if ({frame_err, busy, bm_start, syn_clr} !== 4'b1001) begin
            n_err++;
            $display("FAIL frame_err_pulse: got %b, want 1001", {frame_err, busy, bm_start, syn_clr});
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if ({frame_err, bm_start, busy} !== 3'b000) begin
            n_err++;
            $display("FAIL frame_err_width: got %b, want 000", {frame_err, bm_start, busy});
        end
    endtask

    task automatic test_timeout();
        int cyc = 0;
        feed_bits(N, N);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        #1;
        n_cmp++;
        if (bm_start !== 1'b1) begin
            n_err++;
            $display("FAIL tmo_bm_start: got %b, want 1", bm_start);
        end
        while (cyc < 200) begin
            @(negedge clk);
            #1;
            cyc++;
            if (tmo_err === 1'b1) break;
        end
        n_cmp++;
        if (cyc != BM_TMO || busy !== 1'b0) begin
            n_err++;
            $display("FAIL tmo_latency: cycles=%0d busy=%b, want cycles=%0d busy=0", cyc, busy, BM_TMO);
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if ({tmo_err, busy, out_valid} !== 3'b000) begin
            n_err++;
            $display("FAIL tmo_after: got %b, want 000", {tmo_err, busy, out_valid});
        end
    endtask

    task automatic test_chien_stall();
        int acc = 0;
        int cyc = 0;
        feed_bits(N, N);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        bm_done  = 1'b1;
        #1;
        n_cmp++;
        if (bm_start !== 1'b1) begin
            n_err++;
            $display("FAIL stall_bm_start: got %b, want 1", bm_start);
        end
        while (acc < N) begin
            @(negedge clk);
            bm_done   = 1'b0;
            out_ready = (cyc % 2 == 0);
            #1;
            n_cmp++;
            if ({out_valid, chien_en, done} !== {1'b1, out_ready, 1'b0} || chien_idx !== CNT_W'(acc)) begin
                n_err++;
                $display("FAIL stall_cyc%0d: flags=%b idx=%0d, want flags=%b idx=%0d",
                         cyc, {out_valid, chien_en, done}, chien_idx, {1'b1, out_ready, 1'b0}, acc);
            end
            if (out_ready) acc++;
            cyc++;
        end
        @(negedge clk);
        out_ready = 1'b0;
        #1;
        n_cmp++;
        if ({done, busy} !== 2'b10) begin
            n_err++;
            $display("FAIL stall_done: got %b, want 10", {done, busy});
        end
    endtask

    task automatic test_abort_reset();
        int done_seen = 0;
        feed_bits(7, 0);
        @(negedge clk);
        in_valid = 1'b1;
        abort    = 1'b1;
        @(negedge clk);
        abort    = 1'b0;
        in_valid = 1'b0;
        #1;
        n_cmp++;
        if ({busy, frame_err, done, bm_start, syn_clr} !== 5'b00001) begin
            n_err++;
            $display("FAIL abort_syn: got %b, want 00001", {busy, frame_err, done, bm_start, syn_clr});
        end
        feed_bits(N, N);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        bm_done  = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            bm_done   = 1'b0;
            out_ready = 1'b1;
        end
        #1;
        n_cmp++;
        if (chien_idx !== CNT_W'(5) || out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL pre_reset_idx: idx=%0d valid=%b, want idx=5 valid=1", chien_idx, out_valid);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (outs() !== 10'b0001000000 || chien_idx !== '0) begin
            n_err++;
            $display("FAIL async_reset: outs=%b idx=%0d, want outs=0001000000 idx=0", outs(), chien_idx);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            if (done === 1'b1 || busy === 1'b1) done_seen++;
        end
        out_ready = 1'b0;
        n_cmp++;
        if (done_seen != 0) begin
            n_err++;
            $display("FAIL reset_no_done: busy/done cycles=%0d, want 0", done_seen);
        end
    endtask

    // Frame-level model: after the bubble every valid cycle is one accepted bit; the frame is good
    // only when in_last sits on bit N, otherwise frame_err follows the offending bit.
    task automatic test_random_frames();
        int last_pos, nacc, sent, d, acc;
        bit good;
        for (int f = 0; f < 25; f++) begin
            last_pos = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, N + 1)) : N;
            nacc     = (last_pos > N) ? N : last_pos;
            good     = (last_pos == N);
            @(negedge clk);
            in_valid = 1'b1;
            in_last  = 1'b0;
            #1;
            n_cmp++;
            if ({in_ready, syn_en, busy} !== 3'b000) begin
                n_err++;
                $display("FAIL rnd%0d_bubble: got %b, want 000", f, {in_ready, syn_en, busy});
            end
            sent = 0;
            while (sent < nacc) begin
                @(negedge clk);
                in_valid = ($urandom_range(0, 9) < 7);
                in_last  = in_valid && (sent + 1 == last_pos);
                #1;
                n_cmp++;
                if ({in_ready, syn_en, bm_start, frame_err} !== {1'b1, in_valid, 2'b00}) begin
                    n_err++;
                    $display("FAIL rnd%0d_syn: got %b, want %b", f,
                             {in_ready, syn_en, bm_start, frame_err}, {1'b1, in_valid, 2'b00});
                end
                if (in_valid) sent++;
            end
            @(negedge clk);
            in_valid = 1'b0;
            in_last  = 1'b0;
            if (!good) begin
                #1;
                n_cmp++;
                if ({frame_err, busy, bm_start} !== 3'b100) begin
                    n_err++;
                    $display("FAIL rnd%0d_err: last_pos=%0d got %b, want 100", f, last_pos,
                             {frame_err, busy, bm_start});
                end
                continue;
            end
            d = $urandom_range(0, 6);
            bm_done = (d == 0);
            #1;
            n_cmp++;
            if ({bm_start, busy, out_valid} !== 3'b110) begin
                n_err++;
                $display("FAIL rnd%0d_bm_start: got %b, want 110", f, {bm_start, busy, out_valid});
            end
            for (int j = 1; j <= d; j++) begin
                @(negedge clk);
                bm_done = (j == d);
                #1;
                n_cmp++;
                if ({bm_start, out_valid, tmo_err} !== 3'b000) begin
                    n_err++;
                    $display("FAIL rnd%0d_bm_wait: got %b, want 000", f, {bm_start, out_valid, tmo_err});
                end
            end
            acc = 0;
            while (acc < N) begin
                @(negedge clk);
                bm_done   = 1'b0;
                out_ready = ($urandom_range(0, 3) != 0);
                #1;
                n_cmp++;
                if ({out_valid, chien_en, done} !== {1'b1, out_ready, 1'b0} || chien_idx !== CNT_W'(acc)) begin
                    n_err++;
                    $display("FAIL rnd%0d_chien: flags=%b idx=%0d, want flags=%b idx=%0d", f,
                             {out_valid, chien_en, done}, chien_idx, {1'b1, out_ready, 1'b0}, acc);
                end
                if (out_ready) acc++;
            end
            @(negedge clk);
            out_ready = 1'b0;
            #1;
            n_cmp++;
            if ({done, busy} !== 2'b10) begin
                n_err++;
                $display("FAIL rnd%0d_done: got %b, want 10", f, {done, busy});
            end
        end
    endtask

    initial begin
        test_reset();
        test_normal_frame();
        test_frame_err();
        test_timeout();
        test_chien_stall();
        test_abort_reset();
        test_random_frames();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
